twos_comp_seq: RTL and testbench

//  Parametrised multi-cycle two's-complement unit for the FP divider datapath.

---
 rtl/twos_comp_seq.sv | 120 ++++++++++++
 tb/tb_twos_comp_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twos_comp_seq.sv
// Multi-cycle two's-complement unit: pass / negate / abs on a WIDTH-bit operand,
// processed CHUNK bits per cycle with a registered carry between chunks.
module twos_comp_seq #(
  parameter int WIDTH = 49,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_sign
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   op_q, op_d;
  logic [PW-1:0]   res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            inv_q, inv_d;
  logic            sign_q, sign_d;

  logic [CHUNK-1:0] x;
  logic [CHUNK:0]   sum;
  logic [PW-1:0]    res_shift;
  logic [PW-1:0]    op_shift;

  // Operand is zero-padded to a whole number of chunks and consumed from the
  // bottom; results shift in from the top so chunk i lands at [i*CHUNK +: CHUNK].
  // Padding bits only ever reach result bits above WIDTH, which are dropped.
  assign x   = op_q[CHUNK-1:0] ^ {CHUNK{inv_q}};
  assign sum = {1'b0, x} + {{CHUNK{1'b0}}, carry_q};

  generate
    if (NCHUNK == 1) begin : g_single
      assign res_shift = sum[CHUNK-1:0];
      assign op_shift  = '0;
    end else begin : g_multi
      assign res_shift = {sum[CHUNK-1:0], res_q[PW-1:CHUNK]};
      assign op_shift  = {{CHUNK{1'b0}}, op_q[PW-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    inv_d     = inv_q;
    sign_d    = sign_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = PW'(in_data);
          sign_d  = in_data[WIDTH-1];
          inv_d   = (in_mode == 2'b01) | ((in_mode == 2'b10) & in_data[WIDTH-1]);
          carry_d = inv_d;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d   = res_shift;
        op_d    = op_shift;
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result flags are only presented while the result itself is valid.
  assign out_data = (state_q == DONE) ? res_q[WIDTH-1:0] : '0;
  assign out_sign = (state_q == DONE) & res_q[WIDTH-1];
  assign out_zero = (state_q == DONE) & (res_q[WIDTH-1:0] == '0);
  assign out_ovf  = (state_q == DONE) & inv_q & sign_q & res_q[WIDTH-1];

endmodule

// File: tb/tb_twos_comp_seq.sv
// Scoreboard bench for twos_comp_seq: several width/chunk configurations run in
// parallel, each with directed corner cases, backpressure, reset abort and random ops.
module tb_twos_comp_seq;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit done [NI];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: actual event missing or unexpected", nm);
  endtask

  for (genvar g = 0; g < NI; g++) begin : h
    localparam int W  = (g == 0) ? 8 : 49;
    localparam int C  = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 7 : (g == 3) ? 8 : 49;
    localparam int NC = (W + C - 1) / C;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] NEG5 = {{(W-3){1'b1}}, 3'b011};
    localparam logic [W-1:0] NEG3 = {{(W-2){1'b1}}, 2'b01};
    localparam logic [W-1:0] NEG9 = {{(W-4){1'b1}}, 4'b0111};
    localparam logic [W-1:0] PAT  = W'(64'hA5A5_A5A5_A5A5_A5A5);

    logic         rst_n, in_valid, in_ready, out_valid, out_ready;
    logic         out_ovf, out_zero, out_sign;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   in_mode;

    logic [W-1:0] q_d [$];
    logic         q_o [$];
    int           acc_cyc = 0;
    logic         prev_v = 1'b0;
    bit           hold = 1'b0;
    bit           rnd = 1'b0;

    twos_comp_seq #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .out_sign  (out_sign)
    );

    always @(posedge clk) begin
      #1;
      out_ready = hold ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic c(input string nm, input logic [63:0] a, input logic [63:0] e);
      chk($sformatf("i%0d_%s", g, nm), a, e);
    endtask

    // Reference: signed-integer view of the operation, result taken mod 2^W.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [1:0] m);
      logic         neg;
      logic [W-1:0] r;
      neg = (m == 2'd1) || ((m == 2'd2) && ($signed(x) < 0));
      r   = neg ? (W'(0) - x) : x;
      return {neg && (x == MINV), r};
    endfunction

    task automatic send(input logic [W-1:0] x, input logic [1:0] m,
                        input logic [W-1:0] er, input logic eo);
      int n = 0;
      while (in_ready !== 1'b1 && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      if (in_ready !== 1'b1) bad($sformatf("i%0d_in_ready_timeout", g));
      in_valid = 1'b1;
      in_data  = x;
      in_mode  = m;
      @(posedge clk); #1;
      acc_cyc = cyc;
      q_d.push_back(er);
      q_o.push_back(eo);
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while ((q_d.size() != 0 || out_valid === 1'b1) && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 400) bad($sformatf("i%0d_drain_timeout", g));
    endtask

    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (out_valid === 1'b1 && !prev_v) c("latency", 64'(cyc - acc_cyc), 64'(NC));
        if (out_valid === 1'b1) c("in_ready_in_done", 64'(in_ready), 64'd0);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (q_d.size() == 0) begin
            bad($sformatf("i%0d_unexpected_output", g));
          end else begin
            logic [W-1:0] ed;
            logic         eo;
            ed = q_d.pop_front();
            eo = q_o.pop_front();
            c("data", 64'(out_data), 64'(ed));
            c("ovf",  64'(out_ovf),  64'(eo));
            c("zero", 64'(out_zero), 64'(ed == '0));
            c("sign", 64'(out_sign), 64'(ed[W-1]));
          end
        end
      end
      prev_v = out_valid;
    end

    initial begin
      int n;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_mode  = '0;
      repeat (3) @(posedge clk);
      #1;
      c("rst_valid", 64'(out_valid), 64'd0);
      c("rst_data",  64'(out_data),  64'd0);
      c("rst_ovf",   64'(out_ovf),   64'd0);
      c("rst_zero",  64'(out_zero),  64'd0);
      c("rst_sign",  64'(out_sign),  64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      c("in_ready_after_rst", 64'(in_ready), 64'd1);

      send(W'(5), 2'd1, NEG5,   1'b0);
      send(MINV,  2'd1, MINV,   1'b1);
      send('0,    2'd1, '0,     1'b0);
      send(ONES,  2'd2, W'(1),  1'b0);
      send(MAXV,  2'd2, MAXV,   1'b0);
      send(PAT,   2'd3, PAT,    1'b0);
      send(W'(1), 2'd1, ONES,   1'b0);
      send(MINV,  2'd2, MINV,   1'b1);
      send(MINV,  2'd0, MINV,   1'b0);
      send(PAT,   2'd0, PAT,    1'b0);
      send(W'(1), 2'd2, W'(1),  1'b0);
      drain();

      // Backpressure: result must hold and no new operand may slip in.
      hold = 1'b1;
      send(W'(3), 2'd1, NEG3, 1'b0);
      n = 0;
      while (out_valid !== 1'b1 && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      if (out_valid !== 1'b1) bad($sformatf("i%0d_bp_valid_timeout", g));
      repeat (5) begin
        in_valid = 1'b1;
        in_data  = W'(7);
        in_mode  = 2'd1;
        @(posedge clk); #1;
        c("bp_valid",    64'(out_valid), 64'd1);
        c("bp_data",     64'(out_data),  64'(NEG3));
        c("bp_in_ready", 64'(in_ready),  64'd0);
      end
      in_valid = 1'b0;
      hold     = 1'b0;
      drain();

      // Reset abort mid-operation.
      send(W'(9), 2'd1, NEG9, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      c("abort_valid", 64'(out_valid), 64'd0);
      c("abort_data",  64'(out_data),  64'd0);
      c("abort_ovf",   64'(out_ovf),   64'd0);
      c("abort_zero",  64'(out_zero),  64'd0);
      c("abort_sign",  64'(out_sign),  64'd0);
      q_d.delete();
      q_o.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      c("abort_in_ready", 64'(in_ready), 64'd1);
      send(W'(1), 2'd1, ONES, 1'b0);
      drain();

      rnd = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        logic [63:0]  r;
        logic [W-1:0] x;
        logic [1:0]   m;
        logic [W:0]   e;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
          0:       x = '0;
          1:       x = MINV;
          2:       x = ONES;
          3:       x = W'(1);
          default: x = r[W-1:0];
        endcase
        m = 2'($urandom_range(0, 3));
        e = model(x, m);
        send(x, m, e[W-1:0], e[W]);
      end
      rnd = 1'b0;
      drain();
      repeat (4) @(posedge clk);
      #1;
      c("final_idle_valid", 64'(out_valid),  64'd0);
      c("final_queue",      64'(q_d.size()), 64'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    int n;
    bit all;
    n   = 0;
    all = 1'b0;
    while (!all && n < 90000) begin
      @(posedge clk);
      n++;
      all = 1'b1;
      foreach (done[i]) if (!done[i]) all = 1'b0;
    end
    if (!all) bad("global_timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
